// File: rtl/cw_regbus_pkg.sv
// cw_regbus_pkg: shared FSM states, bus widths and command-byte field positions
package cw_regbus_pkg;
  localparam int ADDR_W = 6;
  localparam int CNT_W = 16;
  localparam int CMD_RW_BIT = 7;
  localparam int CMD_ADDR_MSB = 5;
  localparam int CMD_ADDR_LSB = 0;
  typedef enum logic [2:0] {
    IDLE, HDR_LEN_LO, HDR_LEN_HI, RESOLVE, WR_DATA, RD_ISSUE, RD_WAIT, RD_SEND
  } state_e;
endpackage

// File: rtl/cmd_reg_master.sv
// cmd_reg_master: byte-stream command decoder driving a register bus with read/write strobes
module cmd_reg_master
  import cw_regbus_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic [7:0]        cmd_data_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  output logic [7:0]        rsp_data_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [ADDR_W-1:0] reg_address,
  output logic [CNT_W-1:0]  reg_bytecnt,
  output logic [7:0]        reg_datai,
  input  logic [7:0]        reg_datao,
  output logic [CNT_W-1:0]  reg_size,
  output logic              reg_read,
  output logic              reg_write,
  output logic              reg_addrvalid,
  output logic [ADDR_W-1:0] reg_hypaddress,
  input  logic [CNT_W-1:0]  reg_hyplen,
  output logic              busy_o
);
  state_e state_q, state_d;
  logic rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0] len_q, len_d, size_q, size_d, bytecnt_q, bytecnt_d, idx_q, idx_d, res;
  logic [7:0] datai_q, datai_d, rsp_data_q, rsp_data_d;
  logic write_q, write_d, read_q, read_d, addrvalid_q, addrvalid_d;
  logic rsp_valid_q, rsp_valid_d, ready_q, ready_d, acc;
  logic [RD_LAT-1:0] sh_q, sh_d;
  always_comb begin
    state_d = state_q;
    rw_d = rw_q;
    addr_d = addr_q;
    len_d = len_q;
    size_d = size_q;
    bytecnt_d = bytecnt_q;
    idx_d = idx_q;
    datai_d = datai_q;
    write_d = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    acc = cmd_valid_i & ready_q;
    res = (len_q != '0) ? len_q : reg_hyplen;
    sh_d = RD_LAT'({sh_q, read_q});
    case (state_q)
      IDLE: if (acc) begin
        state_d = HDR_LEN_LO;
        rw_d = cmd_data_i[CMD_RW_BIT];
        addr_d = cmd_data_i[CMD_ADDR_MSB:CMD_ADDR_LSB];
      end
      HDR_LEN_LO: if (acc) begin
        len_d[7:0] = cmd_data_i;
        state_d = HDR_LEN_HI;
      end
      HDR_LEN_HI: if (acc) begin
        len_d[15:8] = cmd_data_i;
        state_d = RESOLVE;
      end
      RESOLVE: begin
        size_d = res;
        bytecnt_d = '0;
        idx_d = '0;
        state_d = (res == '0) ? IDLE : rw_q ? RD_ISSUE : WR_DATA;
      end
      WR_DATA: if (acc) begin
        write_d = 1'b1;
        datai_d = cmd_data_i;
        bytecnt_d = idx_q;
        idx_d = idx_q + 16'd1;
        state_d = (idx_q == size_q - 16'd1) ? IDLE : WR_DATA;
      end
      RD_ISSUE: state_d = RD_WAIT;
      // sh_q's top bit marks the cycle RD_LAT after the read strobe
      RD_WAIT: if (sh_q[RD_LAT-1]) begin
        rsp_data_d = reg_datao;
        rsp_valid_d = 1'b1;
        state_d = RD_SEND;
      end
      RD_SEND: if (rsp_ready_i) begin
        rsp_valid_d = 1'b0;
        state_d = (bytecnt_q == size_q - 16'd1) ? IDLE : RD_ISSUE;
        bytecnt_d = (bytecnt_q == size_q - 16'd1) ? bytecnt_q : bytecnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
    read_d = state_d == RD_ISSUE;
    ready_d = state_d inside {IDLE, HDR_LEN_LO, HDR_LEN_HI, WR_DATA};
    addrvalid_d = (state_d inside {WR_DATA, RD_ISSUE, RD_WAIT, RD_SEND}) | write_d;
  end
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= IDLE;
      rw_q <= 1'b0;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      bytecnt_q <= '0;
      idx_q <= '0;
      datai_q <= '0;
      write_q <= 1'b0;
      read_q <= 1'b0;
      addrvalid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_valid_q <= 1'b0;
      ready_q <= 1'b0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      len_q <= len_d;
      size_q <= size_d;
      bytecnt_q <= bytecnt_d;
      idx_q <= idx_d;
      datai_q <= datai_d;
      write_q <= write_d;
      read_q <= read_d;
      addrvalid_q <= addrvalid_d;
      rsp_data_q <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q <= ready_d;
      sh_q <= sh_d;
    end
  end
  assign cmd_ready_o = ready_q;
  assign rsp_data_o = rsp_data_q;
  assign rsp_valid_o = rsp_valid_q;
  assign reg_address = addr_q;
  assign reg_hypaddress = addr_q;
  assign reg_bytecnt = bytecnt_q;
  assign reg_datai = datai_q;
  assign reg_size = size_q;
  assign reg_read = read_q;
  assign reg_write = write_q;
  assign reg_addrvalid = addrvalid_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_cmd_reg_master.sv
// tb_cmd_reg_master: directed checks of cmd_reg_master with RD_LAT=1 and RD_LAT=3 instances
module tb_cmd_reg_master;
  logic clk = 1'b0, reset_i = 1'b1, sel = 1'b0;
  logic [7:0] cmd_data = '0;
  logic cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [15:0] hyplen = 16'd8;
  logic ready1, rv1, rd1, wr1, av1, busy1, ready3, rv3, rd3, wr3, av3, busy3;
  logic [7:0] rdata1, datai1, datao1, rdata3, datai3, datao3;
  logic [5:0] addr1, haddr1, addr3, haddr3;
  logic [15:0] cnt1, size1, cnt3, size3;
  logic cmd_ready, rsp_valid, rd_mux;
  logic [7:0] rsp_data;
  int checks = 0, errors = 0;
  int wr_n = 0, rd_n = 0, av_n = 0, bad_n = 0;
  logic [7:0] w_data;
  logic [5:0] w_addr;
  logic [15:0] w_cnt, w_size;
  logic v1;
  logic [7:0] d1;
  logic [2:0] v3;
  logic [7:0] d3 [3];
  always #5 clk = ~clk;
  cmd_reg_master #(.RD_LAT(1)) dut1 (
    .clk(clk), .reset_i(reset_i), .cmd_data_i(cmd_data), .cmd_valid_i(cmd_valid & ~sel),
    .cmd_ready_o(ready1), .rsp_data_o(rdata1), .rsp_valid_o(rv1), .rsp_ready_i(rsp_ready & ~sel),
    .reg_address(addr1), .reg_bytecnt(cnt1), .reg_datai(datai1), .reg_datao(datao1),
    .reg_size(size1), .reg_read(rd1), .reg_write(wr1), .reg_addrvalid(av1),
    .reg_hypaddress(haddr1), .reg_hyplen(hyplen), .busy_o(busy1));
  cmd_reg_master #(.RD_LAT(3)) dut3 (
    .clk(clk), .reset_i(reset_i), .cmd_data_i(cmd_data), .cmd_valid_i(cmd_valid & sel),
    .cmd_ready_o(ready3), .rsp_data_o(rdata3), .rsp_valid_o(rv3), .rsp_ready_i(rsp_ready & sel),
    .reg_address(addr3), .reg_bytecnt(cnt3), .reg_datai(datai3), .reg_datao(datao3),
    .reg_size(size3), .reg_read(rd3), .reg_write(wr3), .reg_addrvalid(av3),
    .reg_hypaddress(haddr3), .reg_hyplen(hyplen), .busy_o(busy3));
  assign cmd_ready = sel ? ready3 : ready1;
  assign rsp_valid = sel ? rv3 : rv1;
  assign rsp_data = sel ? rdata3 : rdata1;
  assign rd_mux = sel ? rd3 : rd1;
  // responder stubs: data 0x10+bytecnt appears exactly RD_LAT cycles after the read strobe
  always @(posedge clk) begin
    v1 <= rd1;
    d1 <= 8'h10 + cnt1[7:0];
    v3 <= {v3[1:0], rd3};
    d3[0] <= 8'h10 + cnt3[7:0];
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign datao1 = v1 ? d1 : 8'h00;
  assign datao3 = v3[2] ? d3[2] : 8'h00;
  always @(negedge clk) if (!reset_i) begin
    if (wr1) begin
      wr_n <= wr_n + 1;
      w_data <= datai1;
      w_addr <= addr1;
      w_cnt <= cnt1;
      w_size <= size1;
    end
    if (rd1) rd_n <= rd_n + 1;
    if (av1) av_n <= av_n + 1;
    if ((rd1 & wr1) | ((rd1 | wr1) & ~av1) | (rd3 & wr3) | ((rd3 | wr3) & ~av3)) bad_n <= bad_n + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    cmd_data = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask
  task automatic recv(input logic [7:0] exp, input string tag);
    int n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("recv_timeout", 32'd0, 32'd1);
    chk(tag, {24'd0, rsp_data}, {24'd0, exp});
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask
  task automatic recv_lat(input logic [7:0] exp, input int lat, input string tag);
    int n = 0;
    time t;
    rsp_ready = 1'b0;
    while (!rd_mux && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("read_timeout", 32'd0, 32'd1);
    t = $time;
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, 32'($time - t), 32'(lat * 10));
    recv(exp, tag);
  endtask
  initial begin
    int a, r, av;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_strobes", {29'd0, rd1, wr1, av1}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rv1}, 32'd0);
    chk("rst_addr", {20'd0, addr1, haddr1}, 32'd0);
    chk("rst_cnt_size", {cnt1, size1}, 32'd0);
    chk("rst_data", {16'd0, datai1, rdata1}, 32'd0);
    reset_i = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, ready1}, 32'd1);
    a = wr_n; av = av_n;
    send(8'h26); send(8'h01); send(8'h00); send(8'hA5);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("w1_count", 32'(wr_n - a), 32'd1);
    chk("w1_addr", {26'd0, w_addr}, 32'd38);
    chk("w1_cnt", {16'd0, w_cnt}, 32'd0);
    chk("w1_data", {24'd0, w_data}, 32'hA5);
    chk("w1_size", {16'd0, w_size}, 32'd1);
    chk("w1_av_cycles", 32'(av_n - av), 32'd2);
    chk("w1_busy", {31'd0, busy1}, 32'd0);
    r = rd_n;
    send(8'hB7); send(8'h00); send(8'h00);
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) recv_lat(8'(8'h10 + i), 2, "r8_byte");
    repeat (3) @(negedge clk);
    chk("r8_reads", 32'(rd_n - r), 32'd8);
    chk("r8_size", {16'd0, size1}, 32'd8);
    chk("r8_addr", {20'd0, addr1, haddr1}, {20'd0, 6'd55, 6'd55});
    chk("r8_busy", {31'd0, busy1}, 32'd0);
    r = rd_n;
    send(8'h85); send(8'h03); send(8'h00);
    cmd_valid = 1'b0;
    recv(8'h10, "stall_b0");
    begin
      int n = 0, r1;
      while (!rv1 && n < 200) begin @(negedge clk); n++; end
      r1 = rd_n;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("stall_hold", {23'd0, rv1, rdata1}, {23'd0, 1'b1, 8'h11});
      end
      chk("stall_no_read", 32'(rd_n - r1), 32'd0);
    end
    recv(8'h11, "stall_b1");
    recv(8'h12, "stall_b2");
    repeat (3) @(negedge clk);
    chk("stall_reads", 32'(rd_n - r), 32'd3);
    hyplen = 16'd0;
    a = wr_n; r = rd_n; av = av_n;
    send(8'h03); send(8'h00); send(8'h00);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("zero_busy", {31'd0, busy1}, 32'd0);
    chk("zero_strobes", 32'((wr_n - a) + (rd_n - r) + (av_n - av)), 32'd0);
    hyplen = 16'd8;
    a = wr_n;
    send(8'h0A); send(8'h04); send(8'h00); send(8'h11); send(8'h22);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_state", {27'd0, busy1, ready1, av1, rd1, wr1}, 32'd0);
    chk("mid_rst_regs", {size1, cnt1}, 32'd0);
    reset_i = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, ready1}, 32'd1);
    chk("mid_rst_writes", 32'(wr_n - a), 32'd2);
    chk("mid_rst_last", {16'd0, w_cnt[7:0], w_data}, {16'd0, 8'd1, 8'h22});
    r = rd_n;
    send(8'h91); send(8'h02); send(8'h00);
    cmd_valid = 1'b0;
    recv_lat(8'h10, 2, "fresh_b0");
    recv_lat(8'h11, 2, "fresh_b1");
    repeat (3) @(negedge clk);
    chk("fresh_reads", 32'(rd_n - r), 32'd2);
    chk("fresh_writes", 32'(wr_n - a), 32'd2);
    sel = 1'b1;
    send(8'hA0); send(8'h02); send(8'h00);
    cmd_valid = 1'b0;
    recv_lat(8'h10, 4, "lat3_b0");
    recv_lat(8'h11, 4, "lat3_b1");
    repeat (3) @(negedge clk);
    chk("lat3_size", {16'd0, size3}, 32'd2);
    chk("lat3_busy", {31'd0, busy3}, 32'd0);
    sel = 1'b0;
    chk("no_bad_strobes", 32'(bad_n), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/cmd_reg_master.md
CMD_REG_MASTER -- requirements
Module: cmd_reg_master

Interface
REQ-001 Parameter RD_LAT, default 1, cycles from the reg_read pulse to the cycle reg_datao is sampled; legal range 1..4.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset_i  input  1  synchronous, active-high reset.
REQ-004 cmd_data_i  input  8  host-to-FPGA command/data byte stream.
REQ-005 cmd_valid_i / cmd_ready_o  input / output  1 / 1  byte handshake; transfer when both are high on a clk edge.
REQ-006 rsp_data_o  output  8  FPGA-to-host read-data byte.
REQ-007 rsp_valid_o / rsp_ready_i  output / input  1 / 1  response handshake; transfer when both are high.
REQ-008 reg_address  output  6  register address.
REQ-009 reg_bytecnt  output  16  byte index within the current transaction.
REQ-010 reg_datai  output  8  write data to responders.
REQ-011 reg_datao  input  8  read data from responders (OR of responder outputs; 0 when none selected).
REQ-012 reg_size  output  16  total byte count of the current transaction.
REQ-013 reg_read / reg_write  output  1 / 1  single-cycle read / write strobes.
REQ-014 reg_addrvalid  output  1  high for the whole data phase of a transaction.
REQ-015 reg_hypaddress / reg_hyplen  output 6 / input 16  length query: address out, responder-declared length in.
REQ-016 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 Header SHALL be 3 bytes: CMD = {RW[7], reserved[6], ADDR[5:0]} with RW=1 meaning read; then LEN_LO; then LEN_HI.
REQ-018 States SHALL be IDLE, HDR_LEN_LO, HDR_LEN_HI, RESOLVE, WR_DATA, RD_ISSUE, RD_WAIT, RD_SEND.
REQ-019 IDLE, HDR_LEN_LO and HDR_LEN_HI SHALL hold cmd_ready_o=1 and advance one state per accepted byte.
REQ-020 Once CMD is accepted, reg_address and reg_hypaddress SHALL equal ADDR until the next CMD.
REQ-021 RESOLVE takes 1 cycle; reg_size = {LEN_HI,LEN_LO} if non-zero, else reg_hyplen sampled in RESOLVE.
REQ-022 If the resolved size is 0, the FSM SHALL return to IDLE with no strobe and no addrvalid.
REQ-023 Otherwise reg_addrvalid SHALL go high the cycle after RESOLVE, reg_bytecnt SHALL reset to 0, and the FSM SHALL enter WR_DATA (RW=0) or RD_ISSUE (RW=1).
REQ-024 WR_DATA: cmd_ready_o=1; on accepting byte k, the next cycle SHALL have reg_write=1, reg_datai=byte, reg_bytecnt=k; max throughput 1 byte/cycle.
REQ-025 After the write of byte reg_size-1, the FSM SHALL go to IDLE and drop reg_addrvalid the following cycle.
REQ-026 RD_ISSUE SHALL pulse reg_read for 1 cycle with reg_bytecnt=k, then wait RD_LAT cycles in RD_WAIT.
REQ-027 The FSM SHALL capture reg_datao into rsp_data_o and assert rsp_valid_o, holding both stable until rsp_ready_i.
REQ-028 After the RD_SEND handshake, k SHALL increment; if k = reg_size the FSM goes to IDLE, else back to RD_ISSUE.
REQ-029 cmd_ready_o SHALL be 0 in RESOLVE and in all read states; cmd bytes are not consumed during a read.
REQ-030 reg_read and reg_write SHALL never be high in the same cycle, and each SHALL be high only while reg_addrvalid=1.
REQ-031 reg_bytecnt SHALL be 16-bit unsigned; reg_size=65535 is legal and the final index is 65534 with no wrap.
REQ-032 All bus outputs SHALL be registered; no combinational path from cmd_*/rsp_ready_i to reg_* outputs.

Reset
REQ-033 On reset_i=1 at a clk edge: state=IDLE, all strobes 0, reg_addrvalid=0, rsp_valid_o=0, cmd_ready_o=0, busy_o=0, and reg_address, reg_bytecnt, reg_size, reg_datai, rsp_data_o, reg_hypaddress = 0.
REQ-034 Reset mid-transaction SHALL abandon it with no further strobes; cmd_ready_o SHALL be 1 the first cycle after reset deasserts.

Structure
REQ-035 Shared package cw_regbus_pkg SHALL hold the FSM state enum, address width 6, bytecnt width 16, and CMD bit positions (RW=7, ADDR=5:0).
REQ-036 Flat FSM plus a counter; no sub-module; the RD_LAT delay is a shift register in the same module.

Verification
REQ-037 Write 0x26 len 1 data 0xA5 -> one reg_write cycle, addr 38, bytecnt 0, datai 0xA5, size 1; addrvalid high exactly 2 cycles.
REQ-038 Read 0xB7 len 0, reg_hyplen=8, stub returns 0x10+bytecnt -> 8 rsp bytes 0x10..0x17, reg_size 8, 8 reg_read pulses.
REQ-039 Read len 3 with rsp_ready_i low for 5 cycles on byte 1 -> rsp_data_o held stable, no extra reg_read, bytes in order.
REQ-040 Write len 0 with reg_hyplen=0 -> no strobes, no addrvalid, busy_o back to 0 within 2 cycles of LEN_HI.
REQ-041 Reset asserted after byte 2 of a 4-byte write -> exactly 2 reg_write pulses total, then a fresh read completes correctly.
REQ-042 RD_LAT=3 build, read len 2 -> sample occurs 3 cycles after each reg_read; data matches stub.
